// File: rtl/btn_debounce_pulse_if.sv
// Button conditioning bus: raw button in, debounced level and event pulses out.
// dbg_state mirrors the debouncer FSM state so checkers can observe it directly.
interface btn_debounce_pulse_if;
  logic       i_btn;
  logic       o_level;
  logic       o_press;
  logic       o_release;
  logic       o_long;
  logic [1:0] dbg_state;

  // master drives the raw button and watches the conditioned outputs
  modport master (
    output i_btn,
    input  o_level,
    input  o_press,
    input  o_release,
    input  o_long,
    input  dbg_state
  );

  modport slave (
    input  i_btn,
    output o_level,
    output o_press,
    output o_release,
    output o_long,
    output dbg_state
  );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, registered
// single-cycle press/release pulses and a once-per-press long-press pulse.
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  btn_debounce_pulse_if.slave  bus
);

  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HOLD_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  state_t              state_q;
  logic                sync1_q;
  logic                sync2_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_d;
  logic                long_fired_q;
  logic                level_q;
  logic                press_q;
  logic                release_q;
  logic                long_q;
  logic                btn_s;
  logic                release_accept;
  logic                hold_active;

  // i_btn is asynchronous: only sync1_q ever samples it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.i_btn;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s  = sync2_q;
  assign cnt_d  = cnt_q + CNT_W'(1);
  assign hold_d = hold_q + HOLD_W'(1);

  assign release_accept = (state_q == S_FALL) && !btn_s && (cnt_q == CNT_LAST);
  // The release edge never also fires o_long, so the two pulses stay exclusive
  assign hold_active = (state_q == S_HIGH) || ((state_q == S_FALL) && !release_accept);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_LOW;
      cnt_q        <= '0;
      hold_q       <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;

      unique case (state_q)
        S_LOW: begin
          if (btn_s) begin
            state_q <= S_RISE;
            cnt_q   <= '0;
          end
        end
        S_RISE: begin
          if (!btn_s) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= S_HIGH;
            level_q      <= 1'b1;
            press_q      <= 1'b1;
            hold_q       <= '0;
            long_fired_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HIGH: begin
          if (!btn_s) begin
            state_q <= S_FALL;
            cnt_q   <= '0;
          end
        end
        S_FALL: begin
          // a bounce back high keeps the press alive and the hold count intact
          if (btn_s) begin
            state_q <= S_HIGH;
          end else if (release_accept) begin
            state_q   <= S_LOW;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_LOW;
      endcase

      if (hold_active && !long_fired_q) begin
        if (hold_q == HOLD_LAST) begin
          long_q       <= 1'b1;
          long_fired_q <= 1'b1;
        end else begin
          hold_q <= hold_d;
        end
      end
    end
  end

  assign bus.o_level   = level_q;
  assign bus.o_press   = press_q;
  assign bus.o_release = release_q;
  assign bus.o_long    = long_q;
  assign bus.dbg_state = state_q;

endmodule
